// File: rtl/vram_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : vram_fetch_if
// Description : Bundle of the command, VRAM-arbiter and read-stream signals of
//               the vram_fetch initiator.
//               master : the fetch unit (drives busy/done, the VRAM request and
//                        the read stream)
//               slave  : the environment (issues commands, answers requests,
//                        consumes words)
//               Command  : start, start_addr[14:0], word_count[CNT_W-1:0],
//                          busy, done
//               VRAM     : vram_addr[14:0], vram_strobe, vram_ack,
//                          vram_rddata[31:0]
//               Stream   : rd_data[31:0], rd_valid, rd_ready
// Revision    : 1.0 - initial release
// ============================================================================
interface vram_fetch_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [14:0]      start_addr;
    logic [CNT_W-1:0] word_count;
    logic             busy;
    logic             done;
    logic [14:0]      vram_addr;
    logic             vram_strobe;
    logic             vram_ack;
    logic [31:0]      vram_rddata;
    logic [31:0]      rd_data;
    logic             rd_valid;
    logic             rd_ready;

    modport master (
        input  start, start_addr, word_count, vram_ack, vram_rddata, rd_ready,
        output busy, done, vram_addr, vram_strobe, rd_data, rd_valid
    );

    modport slave (
        output start, start_addr, word_count, vram_ack, vram_rddata, rd_ready,
        input  busy, done, vram_addr, vram_strobe, rd_data, rd_valid
    );
endinterface
`default_nettype wire

// File: rtl/vram_fetch.sv
`default_nettype none
// ============================================================================
// Module      : vram_fetch
// Description : Read initiator for one 32-bit port of the VRAM arbiter.
//               A (start_addr, word_count) command is turned into a sequence
//               of strobe/address requests, at most one in flight, and the
//               acked words are collected in a small show-ahead FIFO drained
//               through a valid/ready stream.
//               Ports: clk, rst (synchronous, active high)
//                      bus (vram_fetch_if.master): command, VRAM request and
//                      read-stream signals
//               Parameters: DEPTH (FIFO words, power of two >= 2),
//                           CNT_W (width of word_count)
// Revision    : 1.0 - initial release
// ============================================================================
module vram_fetch #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    vram_fetch_if.master     bus
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FETCH = 1'b1;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [14:0]      r_iaddr;
    logic [CNT_W-1:0] r_remaining;
    logic             r_discard;
    logic             r_done;

    logic [31:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    // ------------------------------------------------------------------------
    // Decoded events
    // ------------------------------------------------------------------------
    logic             w_fetch;
    logic             w_zero_cmd;
    logic             w_restart;
    logic             w_ack_acc;
    logic             w_last;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_rem_after;
    logic [AW+1:0]    w_occ_ack;

    assign w_fetch    = (r_state == S_FETCH);
    assign w_zero_cmd = bus.start && (bus.word_count == '0);
    assign w_restart  = bus.start && w_fetch;

    // An ack is only taken while fetching, outside the one-cycle discard
    // window and not in a cycle where a new command replaces the old one.
    assign w_ack_acc  = w_fetch && bus.vram_ack && !r_discard && !bus.start;
    assign w_last     = w_ack_acc && (r_remaining == CNT_W'(1));

    assign w_push     = w_ack_acc;
    // A restart flushes the FIFO, so a pop in that cycle is meaningless.
    assign w_pop      = (r_count != '0) && bus.rd_ready && !w_restart;

    assign w_rem_after = r_remaining - CNT_W'(w_ack_acc);

    // Occupancy check counts the raw ack (even one about to be discarded) and
    // ignores a concurrent pop: conservative, and it keeps the request path
    // free of the consumer's ready.
    assign w_occ_ack  = {1'b0, r_count} + {{(AW+1){1'b0}}, bus.vram_ack};

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !w_zero_cmd) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.start) begin
                    // A restart with a zero count aborts and goes idle.
                    w_state_nxt = w_zero_cmd ? S_IDLE : S_FETCH;
                end else if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        bus.busy        = 1'b0;
        bus.done        = r_done;
        bus.vram_strobe = 1'b0;
        // Look-ahead address: when this cycle's ack is taken, the request for
        // the following word goes out immediately, sustaining one word/clock.
        bus.vram_addr   = r_iaddr + 15'(w_ack_acc);
        if (w_fetch) begin
            bus.busy        = 1'b1;
            bus.vram_strobe = (w_rem_after != '0) &&
                              (w_occ_ack < (AW+2)'(DEPTH));
        end
    end

    // ------------------------------------------------------------------------
    // Command registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iaddr     <= '0;
            r_remaining <= '0;
            r_discard   <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_done    <= w_zero_cmd || w_last;
            // An ack in the cycle after a restart answers a request of the
            // aborted command and must be dropped.
            r_discard <= w_restart;
            if (bus.start) begin
                r_iaddr     <= bus.start_addr;
                r_remaining <= bus.word_count;
            end else if (w_ack_acc) begin
                r_iaddr     <= r_iaddr + 15'd1;
                r_remaining <= r_remaining - CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.vram_rddata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_restart) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.rd_valid = (r_count != '0);
    assign bus.rd_data  = r_mem[r_rptr];

    // The strobe rule must never let a word land in a full FIFO.
    always_ff @(posedge clk) begin
        if (!rst && w_push && !w_pop) begin
            assert (r_count < (AW+1)'(DEPTH));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_fetch
// Description : Self-checking bench for vram_fetch. A behavioural arbiter
//               answers requests with address-derived data; a queue-based
//               reference model predicts busy, done, strobe, address and the
//               word stream cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_fetch;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vram_fetch_if #(.CNT_W(CNT_W)) bus ();

    vram_fetch #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Stimulus controls
    logic             drv_rst   = 1'b1;
    logic             drv_start = 1'b0;
    logic [14:0]      drv_addr  = '0;
    logic [CNT_W-1:0] drv_cnt   = '0;
    int               p_grant   = 100;
    int               p_ready   = 100;
    int               deny_n    = 0;
    logic [14:0]      deny_addr = '0;

    // Arbiter state
    logic             ack_pend  = 1'b0;
    logic [31:0]      ack_data  = '0;

    // Reference model
    bit               m_busy    = 1'b0;
    bit               m_discard = 1'b1;
    bit               m_done    = 1'b0;
    logic [14:0]      m_addr    = '0;
    int               m_left    = 0;
    logic [31:0]      m_fifo [$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [14:0] a);
        return {1'b0, a, 1'b1, a} ^ 32'h1234_5678;
    endfunction

    // One clock cycle: apply inputs, check outputs at negedge, let the arbiter
    // decide, then advance the model across the rising edge.
    task automatic cyc();
        logic        acc;
        logic        pop;
        logic        grant;
        logic        st;
        logic        nd;
        logic        ndisc;
        logic        nxt_pend;
        logic [31:0] nxt_data;

        bus.vram_ack    = ack_pend;
        bus.vram_rddata = ack_pend ? ack_data : $urandom();
        bus.start       = drv_start;
        bus.start_addr  = drv_addr;
        bus.word_count  = drv_cnt;
        rst             = drv_rst;
        bus.rd_ready    = ($urandom_range(99) < p_ready);

        acc = m_busy && ack_pend && !m_discard && !drv_start;

        @(negedge clk);
        if (!drv_rst) begin
            check("busy", {31'd0, bus.busy}, {31'd0, m_busy});
            check("done", {31'd0, bus.done}, {31'd0, m_done});
            check("rd_valid", {31'd0, bus.rd_valid}, {31'd0, m_fifo.size() != 0});
            if (m_fifo.size() != 0) begin
                check("rd_data", bus.rd_data, m_fifo[0]);
            end
            st = m_busy && ((m_left - int'(acc)) != 0) &&
                 ((m_fifo.size() + int'(ack_pend)) < DEPTH);
            check("strobe", {31'd0, bus.vram_strobe}, {31'd0, st});
            if (st) begin
                check("addr", {17'd0, bus.vram_addr}, {17'd0, m_addr + 15'(acc)});
            end
        end

        grant = (bus.vram_strobe === 1'b1) && ($urandom_range(99) < p_grant);
        if (deny_n > 0 && bus.vram_strobe === 1'b1 && bus.vram_addr === deny_addr) begin
            grant = 1'b0;
            deny_n--;
        end
        nxt_pend = grant;
        nxt_data = word_of(bus.vram_addr);
        pop      = (m_fifo.size() != 0) && bus.rd_ready;

        @(posedge clk);
        #1;
        if (drv_rst) begin
            m_busy    = 1'b0;
            m_discard = 1'b1;
            m_done    = 1'b0;
            m_fifo.delete();
        end else begin
            nd    = 1'b0;
            ndisc = 1'b0;
            if (drv_start) begin
                if (m_busy) begin
                    m_fifo.delete();
                    ndisc = 1'b1;
                end else if (pop) begin
                    void'(m_fifo.pop_front());
                end
                if (drv_cnt == 0) begin
                    m_busy = 1'b0;
                    nd     = 1'b1;
                end else begin
                    m_busy = 1'b1;
                    m_addr = drv_addr;
                    m_left = int'(drv_cnt);
                end
            end else begin
                if (pop) begin
                    void'(m_fifo.pop_front());
                end
                if (acc) begin
                    m_fifo.push_back(word_of(m_addr));
                    m_addr = m_addr + 15'd1;
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 1'b0;
                        nd     = 1'b1;
                    end
                end
            end
            m_done    = nd;
            m_discard = ndisc;
        end
        ack_pend = nxt_pend;
        ack_data = nxt_data;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
        end
    endtask

    task automatic issue(input logic [14:0] a, input logic [CNT_W-1:0] c);
        drv_start = 1'b1;
        drv_addr  = a;
        drv_cnt   = c;
        cyc();
        drv_start = 1'b0;
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.start_addr  = '0;
        bus.word_count  = '0;
        bus.vram_ack    = 1'b0;
        bus.vram_rddata = '0;
        bus.rd_ready    = 1'b0;

        // Reset, then idle cycles check the reset state
        drv_rst = 1'b1;
        run(2);
        drv_rst = 1'b0;
        run(2);

        // Basic burst, always granted
        issue(15'h0010, 8'd4);
        run(8);

        // Stall three cycles on the second word
        deny_addr = 15'h0011;
        deny_n    = 3;
        issue(15'h0010, 8'd4);
        run(12);
        deny_n = 0;

        // Back-pressure: consumer stalled, then resumes
        p_ready = 0;
        issue(15'h0040, 8'd8);
        run(12);
        p_ready = 100;
        run(15);

        // Address wrap, then a zero-length command
        issue(15'h7FFE, 8'd3);
        run(8);
        issue(15'h0123, 8'd0);
        run(3);

        // Restart mid-burst with the consumer stalled
        p_ready = 0;
        issue(15'h0100, 8'd8);
        run(3);
        issue(15'h0200, 8'd4);
        run(3);
        p_ready = 100;
        run(10);

        // Reset with a request pending
        issue(15'h0300, 8'd8);
        run(3);
        drv_rst = 1'b1;
        cyc();
        drv_rst = 1'b0;
        run(4);

        // Randomized traffic
        for (int blk = 0; blk < 10; blk++) begin
            p_grant = 30 + int'($urandom_range(70));
            p_ready = int'($urandom_range(100));
            for (int i = 0; i < 200; i++) begin
                drv_rst   = ($urandom_range(399) == 0);
                drv_start = ($urandom_range(29) == 0);
                drv_addr  = ($urandom_range(3) == 0) ? 15'(15'h7FF8 + 15'($urandom_range(7)))
                                                     : 15'($urandom());
                drv_cnt   = CNT_W'($urandom_range(12));
                cyc();
            end
        end
        drv_rst   = 1'b0;
        drv_start = 1'b0;
        p_ready   = 100;
        p_grant   = 100;
        run(30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
